// File: rtl/mac_pkg.sv
// Shared constants and FSM encoding for the dot-product controller and its MAC.
// Pure definitions; no timing or flow-control behaviour.
package mac_pkg;
    localparam int OP_W  = 8;
    localparam int ACC_W = 16;
    localparam logic [ACC_W-1:0] ACC_MAX = 16'd65535;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/mac.sv
// Saturating unsigned multiply-accumulate: acc <= min(acc + a*b, max), one-cycle update.
// No flow control; zero operands leave the accumulator unchanged, r clears acc and the sticky overflow.
module mac
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             r,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [ACC_W-1:0] acc,
    output logic             of
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             of_q, of_d;
    logic [ACC_W-1:0] prod;
    logic [ACC_W:0]   sum;

    always_comb begin
        prod = ACC_W'(a) * ACC_W'(b);
        sum  = {1'b0, acc_q} + {1'b0, prod};
        acc_d = sum[ACC_W-1:0];
        of_d  = of_q;
        // The overflow flag is sticky until the next clear.
        if (sum[ACC_W]) begin
            acc_d = ACC_MAX;
            of_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            acc_q <= '0;
            of_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            of_q  <= of_d;
        end
    end

    assign acc = acc_q;
    assign of  = of_q;
endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product controller: feeds len a/b pairs into a saturating MAC, done 2 cycles after last transfer.
// Backpressure: in_ready is high only in RUN; pairs offered in other states are ignored.
module mac_dot_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [ACC_W-1:0] res,
    output logic             res_of,
    output logic             done,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic             res_of_q, res_of_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             mac_clr;
    logic [OP_W-1:0]  mac_a, mac_b;
    logic [ACC_W-1:0] mac_acc;
    logic             mac_of;

    assign xfer    = (state_q == ST_RUN) && in_valid;
    assign mac_clr = r || (state_q == ST_CLR);
    assign mac_a   = xfer ? a : '0;
    assign mac_b   = xfer ? b : '0;

    mac u_mac (
        .clk (clk),
        .r   (mac_clr),
        .a   (mac_a),
        .b   (mac_b),
        .acc (mac_acc),
        .of  (mac_of)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_of_d = res_of_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = '0;
                state_d = (len_q != '0) ? ST_RUN : ST_FIN;
            end
            ST_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                // The last product landed in the MAC at the edge entering FIN.
                res_d    = mac_acc;
                res_of_d = mac_of;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_of_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_of_q <= res_of_d;
            done_q   <= done_d;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q != ST_IDLE);
    assign res      = res_q;
    assign res_of   = res_of_q;
    assign done     = done_q;
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed self-checking bench for mac_dot_ctrl.
module tb_mac_dot_ctrl;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             r = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       a = '0;
    logic [7:0]       b = '0;
    logic [15:0]      res;
    logic             res_of;
    logic             done;
    logic             busy;

    int tests = 0;
    int fails = 0;

    mac_dot_ctrl #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .r        (r),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .res      (res),
        .res_of   (res_of),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] av, input logic [7:0] bv);
        logic ok;
        ok       = 1'b0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        a        = 8'hA5;
        b        = 8'h5A;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL xfer_timeout: in_ready never seen, required 1");
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Cycle 1 is the cycle right after the reference edge; returns 99 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 99;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        r = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        r = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (res !== 16'd0) begin fails++; $display("FAIL reset_res: got %0d want 0", res); end
        tests++; if (res_of !== 1'b0) begin fails++; $display("FAIL reset_of: got %b want 0", res_of); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_start(5'd4);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b want 1", busy); end
        send_pair(8'd6, 8'd9);
        send_pair(8'd5, 8'd4);
        send_pair(8'd9, 8'd2);
        send_pair(8'd3, 8'd8);
        wait_done(cyc);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL b2b_latency: got %0d want 2", cyc); end
        tests++; if (res !== 16'd116) begin fails++; $display("FAIL b2b_res: got %0d want 116", res); end
        tests++; if (res_of !== 1'b0) begin fails++; $display("FAIL b2b_of: got %b want 0", res_of); end
        step();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_saturate();
        int cyc;
        do_start(5'd2);
        send_pair(8'd255, 8'd255);
        send_pair(8'd40, 8'd40);
        wait_done(cyc);
        tests++; if (res !== 16'd65535) begin fails++; $display("FAIL sat_res: got %0d want 65535", res); end
        tests++; if (res_of !== 1'b1) begin fails++; $display("FAIL sat_of: got %b want 1", res_of); end
        // New start issued in the very cycle done is high.
        do_start(5'd3);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_on_done: busy got %b want 1", busy); end
        send_pair(8'd6, 8'd7);
        send_pair(8'd5, 8'd5);
        send_pair(8'd3, 8'd11);
        wait_done(cyc);
        tests++; if (res !== 16'd100) begin fails++; $display("FAIL post_sat_res: got %0d want 100", res); end
        tests++; if (res_of !== 1'b0) begin fails++; $display("FAIL post_sat_of: got %b want 0", res_of); end
        step();
    endtask

    task automatic test_gaps();
        int cyc;
        do_start(5'd3);
        send_pair(8'd6, 8'd7);
        gap(2);
        send_pair(8'd5, 8'd5);
        gap(2);
        send_pair(8'd3, 8'd11);
        wait_done(cyc);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL gap_latency: got %0d want 2", cyc); end
        tests++; if (res !== 16'd100) begin fails++; $display("FAIL gap_res: got %0d want 100", res); end
        step();
    endtask

    task automatic test_len_zero();
        int ndone;
        do_start(5'd0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL len0_ready: got %b want 0", in_ready); end
        start = 1'b1;
        len   = 5'd5;
        step();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL len0_early: done got %b want 0", done); end
        step();
        start = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL len0_latency: done got %b want 1 at cycle 3", done); end
        tests++; if (res !== 16'd0) begin fails++; $display("FAIL len0_res: got %0d want 0", res); end
        tests++; if (res_of !== 1'b0) begin fails++; $display("FAIL len0_of: got %b want 0", res_of); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) ndone++;
        end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL busy_start_ignored: extra done %0d want 0", ndone); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL len0_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int ndone;
        do_start(5'd4);
        send_pair(8'd6, 8'd9);
        send_pair(8'd5, 8'd4);
        r        = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        step();
        r        = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            step();
        end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL mid_reset_done: got %0d pulses want 0", ndone); end
        tests++; if (res !== 16'd0) begin fails++; $display("FAIL mid_reset_res: got %0d want 0", res); end
        do_start(5'd1);
        send_pair(8'd7, 8'd8);
        wait_done(cyc);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL after_reset_latency: got %0d want 2", cyc); end
        tests++; if (res !== 16'd56) begin fails++; $display("FAIL after_reset_res: got %0d want 56", res); end
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_back_to_back();
        test_saturate();
        test_gaps();
        test_len_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mac_dot_ctrl.md
MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 Parameter LEN_W, default 5, is the width of the vector-length input (max length 2^LEN_W-1).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 r  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new dot product; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of element pairs; sampled with start.
REQ-006 in_valid  input  1  element pair on a/b is valid.
REQ-007 in_ready  output  1  controller accepts a pair this cycle.
REQ-008 a  input  8  unsigned element of vector A.
REQ-009 b  input  8  unsigned element of vector B.
REQ-010 res  output  16  last completed dot product, held until the next completion.
REQ-011 res_of  output  1  overflow flag belonging to res.
REQ-012 done  output  1  one-cycle pulse: res/res_of just updated.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL use a four-state FSM: IDLE, CLR, RUN, FIN.
REQ-015 IDLE: start=1 SHALL latch len into a length register and go to CLR; start in any other state SHALL be ignored.
REQ-016 CLR: SHALL assert the MAC clear for exactly one cycle and zero the element counter; next state RUN if latched len>0, else FIN.
REQ-017 RUN: in_ready SHALL be 1; a transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-018 A transfer SHALL drive a/b to the MAC operands; on a non-transfer cycle MAC operands SHALL be 0 so the accumulator is unchanged.
REQ-019 Each transfer SHALL increment the counter; the transfer with count=len-1 SHALL move the FSM to FIN at that edge.
REQ-020 FIN: in_ready=0, MAC operands 0; at the end of FIN, res SHALL load the MAC accumulator, res_of the MAC overflow flag, done SHALL be set for the following cycle, and FSM returns to IDLE.
REQ-021 Arithmetic: accumulator = sum of a*b, 16-bit unsigned, saturating at 65535; overflow flag SHALL set when any addition exceeds 65535 and stay set until the next CLR.
REQ-022 Latency: done SHALL go high exactly 2 cycles after the edge sampling the last transfer (len=0: 3 cycles after the edge sampling start).
REQ-023 in_ready SHALL be 0 in IDLE, CLR and FIN; in_valid there SHALL have no effect.
REQ-024 A start in the same cycle as done SHALL be accepted (FSM is in IDLE).
REQ-025 Counter width SHALL be LEN_W; no wrap occurs because the FSM leaves RUN at count=len-1.

Reset
REQ-026 r=1 SHALL, at the next edge, force IDLE, counter=0, length register=0, res=0, res_of=0, done=0, and clear the MAC accumulator and overflow flag.
REQ-027 r asserted mid-RUN SHALL abandon the operation with no done pulse and res unchanged from reset value 0.
REQ-028 r SHALL dominate start and in_valid in the same cycle.

Structure
REQ-029 A shared package (mac_pkg) SHALL hold the FSM state encoding, operand width 8, accumulator width 16, and saturation constant 65535.
REQ-030 The block SHALL instantiate one existing mac sub-module (clock clk, clear r, operands a/b, outputs acc/of); its clear SHALL be r OR (state==CLR).

Verification
REQ-031 len=4, pairs (6,9),(5,4),(9,2),(3,8) back-to-back -> done once, res=116, res_of=0.
REQ-032 len=2, pairs (255,255),(40,40) -> res=65535, res_of=1; following run len=3, (6,7),(5,5),(3,11) -> res=100, res_of=0.
REQ-033 len=3 with in_valid low for 2 cycles between each pair, same data (6,7),(5,5),(3,11) -> res=100; done 2 cycles after last transfer.
REQ-034 len=0 -> done 3 cycles after start, res=0, res_of=0; start while busy ignored (no second done).
REQ-035 r pulsed after 2 of 4 transfers -> busy=0, done never pulses, res=0; a new len=1 run (7,8) -> res=56.
